module_serial_subtractor: RTL and testbench
===========================================

Name: module_serial_subtractor

Overview:
- Bit-serial companion to the parallel adder datapath: computes a_i - b_i - borrow_i, one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- Area-cheap alternative to a parallel ripple-borrow subtractor for non-latency-critical paths.
- Operands are accepted on a valid/ready input handshake; the result is returned on a valid/ready output handshake.

Parameters:
- RCAWIDE, 8, operand and result width in bits; legal range is 1 or more.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_n_i  input  1  synchronous active-low reset.
- valid_i  input  1  operand request valid.
- ready_o  output  1  block idle and able to accept operands.
- a_i  input  RCAWIDE  minuend.
- b_i  input  RCAWIDE  subtrahend.
- borrow_i  input  1  borrow-in.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts result.
- diff_o  output  RCAWIDE  difference.
- borrow_o  output  1  borrow-out; 1 iff a_i < b_i + borrow_i.

Behaviour:
- Arithmetic: {borrow_o, diff_o} = ({1'b0,a_i} - {1'b0,b_i} - borrow_i), taken modulo 2^(RCAWIDE+1). borrow_o is bit RCAWIDE of that result.
- Per-bit cell: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br).
- Reset (rst_n_i sampled low at an edge):
  - State goes to IDLE.
  - valid_o = 0, diff_o = 0, borrow_o = 0, bit counter = 0.
  - ready_o = 0 while rst_n_i is low.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - ready_o = 1.
  - On an edge with valid_i && ready_o, latch a_i, b_i and borrow_i into internal shift and borrow registers, clear the counter, and go to RUN.
  - Without that handshake, remain in IDLE.
- RUN:
  - ready_o = 0; valid_i is ignored.
  - Each edge processes operand bit k = counter: the result bit shifts into the result register from the MSB side, the operand registers shift right, the borrow register updates, and counter increments.
  - On the edge processing bit RCAWIDE-1, load diff_o and borrow_o from the final result and borrow, and go to DONE.
- DONE:
  - valid_o = 1; diff_o and borrow_o are held stable; ready_o = 0.
  - On an edge with ready_i = 1, drop valid_o to 0 and go to IDLE. ready_o = 1 in the following cycle.
  - With ready_i = 0, hold indefinitely with outputs unchanged.
- Latency: valid_o rises exactly RCAWIDE cycles after the accept edge. Minimum issue interval is RCAWIDE+2 cycles when ready_i is held at 1.
- Operand inputs may change freely after the accept edge; they do not affect the in-flight result.
- diff_o and borrow_o keep their last result after DONE exits, until the next result is loaded or reset. They are only meaningful while valid_o = 1.
- Reset asserted mid-RUN or mid-DONE aborts the operation: no valid_o pulse, and the outputs are cleared as in Reset.
- RCAWIDE = 1: RUN lasts one cycle.
- All outputs are registered except ready_o, which is decoded from state and rst_n_i.

Test Plan (RCAWIDE = 8):
- Reset then idle: hold rst_n_i = 0 for 3 cycles, then release -> valid_o = 0, diff_o = 0, borrow_o = 0 during reset; ready_o = 1 on the first cycle after release.
- Basic subtract: a = 8'd200, b = 8'd55, borrow_i = 0, ready_i = 1 -> valid_o high exactly 8 cycles after accept, diff_o = 8'd145, borrow_o = 0, valid_o high for 1 cycle, ready_o returns next cycle.
- Underflow wrap: a = 8'h00, b = 8'h01, borrow_i = 1 -> diff_o = 8'hFE, borrow_o = 1. Then a = 8'h00, b = 8'hFF, borrow_i = 1 -> diff_o = 8'h00, borrow_o = 1.
- Backpressure: a = 8'h80, b = 8'h80, borrow_i = 0, ready_i = 0 for 5 cycles after valid_o rises -> diff_o = 8'h00, borrow_o = 0 held stable, ready_o = 0. valid_i pulsed with a = 8'hAA during this window is ignored. ready_i = 1 -> IDLE.
- Reset mid-operation: accept a = 8'h10, b = 8'h01, drive rst_n_i = 0 on cycle 4 of RUN -> no valid_o pulse. A subsequent a = 8'h10, b = 8'h01, borrow_i = 0 -> diff_o = 8'h0F, borrow_o = 0.
- Random: 50 random operand triples with random ready_i stalls, compared against the wide-subtract model; any mismatch is fatal.

Source files
------------

// File: rtl/module_serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell and a borrow flop resolve
// a_i - b_i - borrow_i LSB first over RCAWIDE cycles, with valid/ready on both sides.
module module_serial_subtractor #(
    parameter int RCAWIDE = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [RCAWIDE-1:0] a_i,
    input  logic [RCAWIDE-1:0] b_i,
    input  logic               borrow_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [RCAWIDE-1:0] diff_o,
    output logic               borrow_o
);

    localparam int CW = (RCAWIDE > 1) ? $clog2(RCAWIDE) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(RCAWIDE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {borrow_next, difference_bit} for one bit position.
    function automatic logic [1:0] sub_cell(input logic a, input logic b, input logic br);
        sub_cell = {(~a & b) | (~(a ^ b) & br), a ^ b ^ br};
    endfunction

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [RCAWIDE-1:0] a_q;
    logic [RCAWIDE-1:0] b_q;
    logic               br_q;
    logic [RCAWIDE-1:0] res_q;
    logic               valid_q;
    logic [RCAWIDE-1:0] diff_q;
    logic               borrow_q;

    logic [1:0]         cell_s;
    logic [RCAWIDE:0]   res_ext_s;
    logic [RCAWIDE-1:0] res_d;
    logic [RCAWIDE-1:0] a_d;
    logic [RCAWIDE-1:0] b_d;
    logic               br_d;

    // Serial datapath: next values of the shift registers for the current bit.
    always_comb begin
        cell_s    = sub_cell(a_q[0], b_q[0], br_q);
        res_ext_s = {cell_s[0], res_q};
        res_d     = res_ext_s[RCAWIDE:1];
        br_d      = cell_s[1];
        a_d       = a_q >> 1;
        b_d       = b_q >> 1;
    end

    // Ready is forced low while reset is held so nothing is accepted during it.
    always_comb begin
        ready_o = rst_n_i & (state_q == IDLE);
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= {CW{1'b0}};
            a_q      <= {RCAWIDE{1'b0}};
            b_q      <= {RCAWIDE{1'b0}};
            br_q     <= 1'b0;
            res_q    <= {RCAWIDE{1'b0}};
            valid_q  <= 1'b0;
            diff_q   <= {RCAWIDE{1'b0}};
            borrow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        br_q    <= borrow_i;
                        cnt_q   <= {CW{1'b0}};
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    br_q  <= br_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + CW'(1);
                    // res_d/br_d already include the MSB on the last bit edge.
                    if (cnt_q == LAST_BIT) begin
                        diff_q   <= res_d;
                        borrow_q <= br_d;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        state_q <= RUN;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign valid_o  = valid_q;
    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;

endmodule

// File: tb/tb_module_serial_subtractor.sv
// Directed and randomized checks of module_serial_subtractor (RCAWIDE = 8)
// against a plain wide-subtraction reference.
module tb_module_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n_i;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         borrow_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] diff_o;
    logic         borrow_o;

    int checks = 0;
    int errors = 0;

    module_serial_subtractor #(.RCAWIDE(W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .borrow_i(borrow_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .diff_o  (diff_o),
        .borrow_o(borrow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: wide subtraction modulo 2^(W+1).
    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        ref_sub = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    endfunction

    // Accept one operation, wait for the result, apply stall cycles, release it.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bi, input int stall, input logic pulse);
        int n;
        logic [W:0] exp;
        exp = ref_sub(a, b, bi);
        n = 0;
        while (!ready_o && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_ready_before"}, ready_o, 1'b1);
        ready_i  = (stall == 0);
        a_i      = a;
        b_i      = b;
        borrow_i = bi;
        valid_i  = 1'b1;
        tick();
        valid_i  = 1'b0;
        a_i      = W'($urandom);
        b_i      = W'($urandom);
        borrow_i = 1'($urandom);
        n = 0;
        while (!valid_o && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, W);
        check({tag, "_diff"}, diff_o, exp[W-1:0]);
        check({tag, "_borrow"}, borrow_o, exp[W]);
        for (int i = 0; i < stall; i++) begin
            if (pulse && i == 1) begin
                valid_i = 1'b1;
                a_i     = 8'hAA;
            end else begin
                valid_i = 1'b0;
            end
            tick();
            check({tag, "_hold_valid"}, valid_o, 1'b1);
            check({tag, "_hold_diff"}, {borrow_o, diff_o}, exp);
            check({tag, "_hold_ready"}, ready_o, 1'b0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        check({tag, "_valid_drop"}, valid_o, 1'b0);
        check({tag, "_ready_back"}, ready_o, 1'b1);
        check({tag, "_diff_kept"}, {borrow_o, diff_o}, exp);
    endtask

    initial begin
        int seen;
        rst_n_i  = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        a_i      = '0;
        b_i      = '0;
        borrow_i = 1'b0;

        // Reset then idle
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_valid", valid_o, 1'b0);
            check("rst_diff", diff_o, 8'h00);
            check("rst_borrow", borrow_o, 1'b0);
            check("rst_ready", ready_o, 1'b0);
        end
        rst_n_i = 1'b1;
        #1;
        check("rel_ready", ready_o, 1'b1);
        tick();
        check("idle_ready", ready_o, 1'b1);

        // Directed cases
        run_op("basic", 8'd200, 8'd55, 1'b0, 0, 1'b0);
        check("basic_const_diff", diff_o, 8'd145);
        run_op("uflow1", 8'h00, 8'h01, 1'b1, 0, 1'b0);
        check("uflow1_const", {borrow_o, diff_o}, 9'h1FE);
        run_op("uflow2", 8'h00, 8'hFF, 1'b1, 0, 1'b0);
        check("uflow2_const", {borrow_o, diff_o}, 9'h100);
        run_op("bp", 8'h80, 8'h80, 1'b0, 5, 1'b1);
        check("bp_const", {borrow_o, diff_o}, 9'h000);
        // The AA pulse during DONE must not have started an operation.
        tick();
        check("bp_no_ghost_ready", ready_o, 1'b1);

        // Reset in the middle of RUN
        a_i      = 8'h10;
        b_i      = 8'h01;
        borrow_i = 1'b0;
        valid_i  = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n_i = 1'b0;
        tick();
        check("midrst_valid", valid_o, 1'b0);
        check("midrst_out", {borrow_o, diff_o}, 9'h000);
        check("midrst_ready", ready_o, 1'b0);
        rst_n_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid_o) seen++;
        end
        check("midrst_no_pulse", seen, 0);
        run_op("after_rst", 8'h10, 8'h01, 1'b0, 0, 1'b0);
        check("after_rst_const", {borrow_o, diff_o}, 9'h00F);

        // Randomized operands with random consumer stalls
        for (int i = 0; i < 50; i++) begin
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
